// File: rtl/mau_pkg.sv
// mau_pkg: shared definitions for the Matrix Algebra Unit.
// Provides the opcode encodings, BRAM identifiers, the controller state
// enum and small helpers that slice the fields of a host instruction
// ([7:6] dest BRAM, [5:4] src BRAM, [3:0] opcode).
package mau_pkg;

    localparam logic [3:0] OP_NOP    = 4'b0000;
    localparam logic [3:0] OP_LOAD   = 4'b0100;
    localparam logic [3:0] OP_COPY   = 4'b0101;
    localparam logic [3:0] OP_UNLOAD = 4'b0110;
    localparam logic [3:0] OP_CLEAR  = 4'b0111;
    localparam logic [3:0] OP_ADD    = 4'b1100;

    localparam logic [1:0] B0 = 2'd0;
    localparam logic [1:0] B1 = 2'd1;
    localparam logic [1:0] B2 = 2'd2;
    localparam logic [1:0] B3 = 2'd3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD_S   = 2'd1,
        UNLOAD_S = 2'd2,
        EXEC_S   = 2'd3
    } state_t;

    function automatic logic [1:0] instr_dest(input logic [7:0] instr);
        return instr[7:6];
    endfunction

    function automatic logic [1:0] instr_src(input logic [7:0] instr);
        return instr[5:4];
    endfunction

    function automatic logic [3:0] instr_opcode(input logic [7:0] instr);
        return instr[3:0];
    endfunction

endpackage

// File: rtl/mau_if.sv
// mau_if: host-side bus of the Matrix Algebra Unit.
//   host_instruction : host -> unit, instruction byte sampled when idle
//   data_in          : host -> unit, byte stream for LOAD
//   data_out         : unit -> host, registered byte stream for UNLOAD
//   busy_flag        : unit -> host, high while an instruction executes
// The master modport is the host side, the slave modport is the unit.
interface mau_if;

    logic [7:0] host_instruction;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       busy_flag;

    modport master (
        output host_instruction,
        output data_in,
        input  data_out,
        input  busy_flag
    );

    modport slave (
        input  host_instruction,
        input  data_in,
        output data_out,
        output busy_flag
    );

endinterface

// File: rtl/matrix_bram.sv
// matrix_bram: storage for one matrix as a single flat chunk of bytes.
// Ports:
//   clk, rst        : clock and asynchronous active-high reset (clears all bytes)
//   clear_i         : synchronous clear of the whole chunk (highest priority)
//   wr_chunk_en_i   : write the whole chunk from wr_chunk_i
//   wr_chunk_i      : full-chunk write data
//   wr_byte_en_i    : write one byte wr_byte_i at element wr_offset_i
//   wr_offset_i     : element index for the byte write
//   wr_byte_i       : byte write data
//   rd_offset_i     : element index for the byte read
//   rd_byte_o       : byte at rd_offset_i (combinational)
//   chunk_o         : whole chunk (combinational from the storage register)
module matrix_bram #(
    parameter int CHUNK_W = 512,
    parameter int OFF_W   = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear_i,
    input  logic               wr_chunk_en_i,
    input  logic [CHUNK_W-1:0] wr_chunk_i,
    input  logic               wr_byte_en_i,
    input  logic [OFF_W-1:0]   wr_offset_i,
    input  logic [7:0]         wr_byte_i,
    input  logic [OFF_W-1:0]   rd_offset_i,
    output logic [7:0]         rd_byte_o,
    output logic [CHUNK_W-1:0] chunk_o
);

    logic [CHUNK_W-1:0] chunk_q;
    logic [CHUNK_W-1:0] chunk_d;

    // Clear wins over a full-chunk write, which wins over a byte write;
    // the controller never asserts more than one, but the order keeps
    // the behaviour defined regardless.
    always_comb begin
        chunk_d = chunk_q;
        if (clear_i) begin
            chunk_d = '0;
        end else if (wr_chunk_en_i) begin
            chunk_d = wr_chunk_i;
        end else if (wr_byte_en_i) begin
            chunk_d[{wr_offset_i, 3'b000} +: 8] = wr_byte_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chunk_q <= '0;
        end else begin
            chunk_q <= chunk_d;
        end
    end

    assign rd_byte_o = chunk_q[{rd_offset_i, 3'b000} +: 8];
    assign chunk_o   = chunk_q;

endmodule

// File: rtl/mau_core.sv
// mau_core: Matrix Algebra Unit top level.
// Holds four matrix BRAMs and a small controller that decodes one host
// instruction per idle cycle: LOAD streams bytes in, UNLOAD streams bytes
// out, and COPY / CLEAR / ADD operate on whole chunks in a single cycle.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   host_if  : mau_if slave (host_instruction, data_in, data_out, busy_flag)
module mau_core
    import mau_pkg::*;
#(
    parameter int matrix_dim = 8
) (
    input  logic clk,
    input  logic rst,
    mau_if.slave host_if
);

    localparam int ELEMS   = matrix_dim * matrix_dim;
    localparam int CHUNK_W = 8 * ELEMS;
    localparam int OFF_W   = (ELEMS > 1) ? $clog2(ELEMS) : 1;
    localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(ELEMS - 1);

    state_t           state_q, state_d;
    logic [OFF_W-1:0] offset_q, offset_d;
    logic [1:0]       dest_q, dest_d;
    logic [1:0]       src_q, src_d;
    logic [3:0]       op_q, op_d;
    logic [7:0]       data_out_q, data_out_d;

    logic [CHUNK_W-1:0] chunk [4];
    logic [7:0]         rd_byte [4];
    logic [3:0]         clear_en;
    logic [3:0]         chunk_we;
    logic [3:0]         byte_we;
    logic [OFF_W-1:0]   rd_offset;

    logic [CHUNK_W-1:0] b0_chunk_out;
    logic [CHUNK_W-1:0] b1_chunk_out;
    logic [CHUNK_W-1:0] b2_chunk_out;
    logic [CHUNK_W-1:0] b3_chunk_out;
    logic [1:0]         dd_mux_sel;

    logic [CHUNK_W-1:0] src_chunk;
    logic [CHUNK_W-1:0] dest_chunk;
    logic [CHUNK_W-1:0] sum_chunk;
    logic [CHUNK_W-1:0] exec_chunk;
    logic [7:0]         sel_byte;

    for (genvar i = 0; i < 4; i++) begin : g_bram
        matrix_bram #(
            .CHUNK_W (CHUNK_W),
            .OFF_W   (OFF_W)
        ) u_bram (
            .clk           (clk),
            .rst           (rst),
            .clear_i       (clear_en[i]),
            .wr_chunk_en_i (chunk_we[i]),
            .wr_chunk_i    (exec_chunk),
            .wr_byte_en_i  (byte_we[i]),
            .wr_offset_i   (offset_q),
            .wr_byte_i     (host_if.data_in),
            .rd_offset_i   (rd_offset),
            .rd_byte_o     (rd_byte[i]),
            .chunk_o       (chunk[i])
        );
    end

    assign b0_chunk_out = chunk[0];
    assign b1_chunk_out = chunk[1];
    assign b2_chunk_out = chunk[2];
    assign b3_chunk_out = chunk[3];

    assign src_chunk  = chunk[src_q];
    assign dest_chunk = chunk[dest_q];

    // One independent 8-bit adder per element; carries never cross bytes.
    for (genvar e = 0; e < ELEMS; e++) begin : g_add
        assign sum_chunk[8*e +: 8] = dest_chunk[8*e +: 8] + src_chunk[8*e +: 8];
    end

    assign exec_chunk = (op_q == OP_ADD) ? sum_chunk : src_chunk;

    // While idle the UNLOAD instruction being sampled selects the BRAM so
    // element 0 can be registered at the decode edge; afterwards the
    // latched dest keeps the selection. The read offset looks one element
    // ahead because data_out is registered.
    assign dd_mux_sel = (state_q == IDLE) ? instr_dest(host_if.host_instruction) : dest_q;
    assign rd_offset  = (state_q == UNLOAD_S) ? offset_q + 1'b1 : '0;
    assign sel_byte   = rd_byte[dd_mux_sel];

    // Next-state, counter and BRAM write-enable decode.
    always_comb begin
        state_d    = state_q;
        offset_d   = offset_q;
        dest_d     = dest_q;
        src_d      = src_q;
        op_d       = op_q;
        data_out_d = data_out_q;
        clear_en   = '0;
        chunk_we   = '0;
        byte_we    = '0;

        unique case (state_q)
            IDLE: begin
                dest_d   = instr_dest(host_if.host_instruction);
                src_d    = instr_src(host_if.host_instruction);
                op_d     = instr_opcode(host_if.host_instruction);
                offset_d = '0;
                case (instr_opcode(host_if.host_instruction))
                    OP_LOAD:   state_d = LOAD_S;
                    OP_UNLOAD: begin
                        state_d    = UNLOAD_S;
                        data_out_d = sel_byte;
                    end
                    OP_COPY, OP_CLEAR, OP_ADD: state_d = EXEC_S;
                    default: begin
                        state_d = IDLE;
                        dest_d  = dest_q;
                        src_d   = src_q;
                        op_d    = op_q;
                    end
                endcase
            end

            LOAD_S: begin
                byte_we[dest_q] = 1'b1;
                if (offset_q == LAST_OFF) begin
                    state_d  = IDLE;
                    offset_d = '0;
                end else begin
                    offset_d = offset_q + 1'b1;
                end
            end

            // offset_q is the element currently shown on data_out; the last
            // one is held through the return to idle.
            UNLOAD_S: begin
                if (offset_q == LAST_OFF) begin
                    state_d  = IDLE;
                    offset_d = '0;
                end else begin
                    data_out_d = sel_byte;
                    offset_d   = offset_q + 1'b1;
                end
            end

            EXEC_S: begin
                if (op_q == OP_CLEAR) begin
                    clear_en[dest_q] = 1'b1;
                end else begin
                    chunk_we[dest_q] = 1'b1;
                end
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            offset_q   <= '0;
            dest_q     <= B0;
            src_q      <= B0;
            op_q       <= OP_NOP;
            data_out_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            offset_q   <= offset_d;
            dest_q     <= dest_d;
            src_q      <= src_d;
            op_q       <= op_d;
            data_out_q <= data_out_d;
        end
    end

    assign host_if.data_out  = data_out_q;
    assign host_if.busy_flag = (state_q != IDLE);

endmodule

// File: tb/tb_mau_core.sv
// tb_mau_core: self-checking bench for mau_core (matrix_dim = 8).
// Streams LOAD/UNLOAD sequences by hand, runs a table of single-cycle
// COPY/CLEAR/ADD/NOP vectors, then covers mod-256 wrap and mid-load reset.
module tb_mau_core;
    import mau_pkg::*;

    localparam int ELEMS = 64;

    typedef struct {
        string        name;
        logic [7:0]   instr;
        int           expBusy;
        logic [1:0]   bram;
        logic [511:0] expChunk;
    } vec_t;

    logic clk;
    logic rst;
    mau_if hif ();

    int   compared;
    int   mismatched;
    vec_t vecs [10];

    mau_core #(.matrix_dim(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .host_if (hif.slave)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [511:0] seqChunk(input int mult);
        logic [511:0] c;
        for (int k = 0; k < ELEMS; k++) c[8*k +: 8] = 8'((k + 1) * mult);
        return c;
    endfunction

    function automatic logic [511:0] fillChunk(input logic [7:0] b);
        logic [511:0] c;
        for (int k = 0; k < ELEMS; k++) c[8*k +: 8] = b;
        return c;
    endfunction

    function automatic logic [511:0] chunkOf(input logic [1:0] b);
        case (b)
            2'd0:    return dut.b0_chunk_out;
            2'd1:    return dut.b1_chunk_out;
            2'd2:    return dut.b2_chunk_out;
            default: return dut.b3_chunk_out;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Load 64 bytes into a BRAM: mode 0 streams 1..64, mode 1 streams 0xFF.
    task automatic doLoad(input logic [1:0] b, input int mode);
        int busyCycles;
        hif.host_instruction = {b, 2'b00, OP_LOAD};
        tick();
        hif.host_instruction = 8'h00;
        busyCycles = 0;
        for (int k = 0; k < ELEMS; k++) begin
            hif.data_in = (mode == 0) ? 8'(k + 1) : 8'hFF;
            if (hif.busy_flag) busyCycles++;
            tick();
        end
        checkOutput($sformatf("load B%0d busy cycles", b), 512'(busyCycles), 512'(ELEMS));
        checkOutput($sformatf("load B%0d busy low", b), 512'(hif.busy_flag), 512'(0));
    endtask

    task automatic doUnload(input logic [1:0] b);
        logic [511:0] stream;
        int busyCycles;
        int selErrs;
        hif.host_instruction = {b, 2'b00, OP_UNLOAD};
        tick();
        hif.host_instruction = 8'h00;
        busyCycles = 0;
        selErrs = 0;
        stream = '0;
        for (int k = 0; k < ELEMS; k++) begin
            stream[8*k +: 8] = hif.data_out;
            if (hif.busy_flag) busyCycles++;
            if (dut.dd_mux_sel !== b) selErrs++;
            tick();
        end
        checkOutput($sformatf("unload B%0d stream", b), stream, seqChunk(1));
        checkOutput($sformatf("unload B%0d busy cycles", b), 512'(busyCycles), 512'(ELEMS));
        checkOutput($sformatf("unload B%0d dd_mux_sel errors", b), 512'(selErrs), 512'(0));
        checkOutput($sformatf("unload B%0d busy low", b), 512'(hif.busy_flag), 512'(0));
        checkOutput($sformatf("unload B%0d data_out hold", b), 512'(hif.data_out), 512'(8'h40));
    endtask

    task automatic setVec(input int i, input string name, input logic [7:0] instr,
                          input int expBusy, input logic [1:0] bram, input logic [511:0] expChunk);
        vecs[i].name     = name;
        vecs[i].instr    = instr;
        vecs[i].expBusy  = expBusy;
        vecs[i].bram     = bram;
        vecs[i].expChunk = expChunk;
    endtask

    // One table vector: issue, check busy for the execute cycle, check result.
    task automatic applyStimulus(input int i);
        hif.host_instruction = vecs[i].instr;
        tick();
        hif.host_instruction = 8'h00;
        checkOutput({vecs[i].name, " busy"}, 512'(hif.busy_flag), 512'(vecs[i].expBusy));
        tick();
        checkOutput({vecs[i].name, " busy low"}, 512'(hif.busy_flag), 512'(0));
        checkOutput({vecs[i].name, " chunk"}, chunkOf(vecs[i].bram), vecs[i].expChunk);
    endtask

    // Main sequence.
    initial begin
        compared = 0;
        mismatched = 0;
        rst = 1'b1;
        hif.host_instruction = 8'h00;
        hif.data_in = 8'h00;
        repeat (3) tick();
        rst = 1'b0;

        checkOutput("reset busy", 512'(hif.busy_flag), 512'(0));
        checkOutput("reset data_out", 512'(hif.data_out), 512'(0));
        for (int b = 0; b < 4; b++)
            checkOutput($sformatf("reset B%0d", b), chunkOf(2'(b)), '0);
        for (int n = 0; n < 2; n++) begin
            tick();
            checkOutput($sformatf("nop %0d busy", n), 512'(hif.busy_flag), 512'(0));
        end

        for (int b = 0; b < 4; b++) begin
            doLoad(2'(b), 0);
            checkOutput($sformatf("load B%0d chunk", b), chunkOf(2'(b)), seqChunk(1));
            checkOutput($sformatf("load B%0d first byte", b), 512'(chunkOf(2'(b)) & 512'hFF), 512'(8'h01));
            checkOutput($sformatf("load B%0d last byte", b), 512'(chunkOf(2'(b)) >> 504), 512'(8'h40));
            doUnload(2'(b));
        end

        for (int b = 0; b < 4; b++) begin
            setVec(0, $sformatf("clear B%0d", b), {2'(b), 2'b00, OP_CLEAR}, 1, 2'(b), '0);
            applyStimulus(0);
        end

        doLoad(B0, 0);
        setVec(0, "copy B0->B1",   {B1, B0, OP_COPY}, 1, B1, seqChunk(1));
        setVec(1, "copy B1->B2",   {B2, B1, OP_COPY}, 1, B2, seqChunk(1));
        setVec(2, "copy B2->B3",   {B3, B2, OP_COPY}, 1, B3, seqChunk(1));
        setVec(3, "src B0 kept",   8'h00,             0, B0, seqChunk(1));
        setVec(4, "add B0+=B1",    {B0, B1, OP_ADD},  1, B0, seqChunk(2));
        setVec(5, "add B2+=B3",    {B2, B3, OP_ADD},  1, B2, seqChunk(2));
        setVec(6, "src B3 kept",   8'h0F,             0, B3, seqChunk(1));
        setVec(7, "copy B3->B3",   {B3, B3, OP_COPY}, 1, B3, seqChunk(1));
        setVec(8, "add B1 double", {B1, B1, OP_ADD},  1, B1, seqChunk(2));
        setVec(9, "clear B0",      {B0, B2, OP_CLEAR},1, B0, '0);
        for (int i = 0; i < 10; i++) applyStimulus(i);
        checkOutput("B2 after chain", chunkOf(B2), seqChunk(2));

        doLoad(B0, 1);
        doLoad(B1, 1);
        setVec(0, "add wrap", {B0, B1, OP_ADD}, 1, B0, fillChunk(8'hFE));
        applyStimulus(0);
        checkOutput("add wrap src kept", chunkOf(B1), fillChunk(8'hFF));

        hif.host_instruction = {B2, 2'b00, OP_LOAD};
        tick();
        hif.host_instruction = 8'h00;
        for (int k = 0; k < 10; k++) begin
            hif.data_in = 8'(k + 100);
            tick();
        end
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        checkOutput("midreset busy", 512'(hif.busy_flag), 512'(0));
        checkOutput("midreset data_out", 512'(hif.data_out), 512'(0));
        for (int b = 0; b < 4; b++)
            checkOutput($sformatf("midreset B%0d", b), chunkOf(2'(b)), '0);
        tick();
        checkOutput("midreset idle", 512'(hif.busy_flag), 512'(0));
        checkOutput("midreset B2 stays", chunkOf(B2), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
